pi_controller_mc: RTL and testbench

- Time-multiplexed, multi-channel PI controller for the FOC current loops (default two channels, d and q), with one shared multiplier.
- Sits between the Park transform and inverse Park / SVPWM. It takes per-channel reference and feedback in fixed point and produces clamped voltage commands.
- Adds start/done handshake, per-channel gains, internal output clamping, back-calculation anti-windup and saturating integrators.

---
 rtl/foc_pkg.sv | 44 ++++
 rtl/pi_controller_mc_if.sv | 44 ++++
 rtl/pi_clamp.sv | 46 ++++
 rtl/pi_controller_mc.sv | 213 +++++++++++++++++++++
 tb/tb_pi_controller_mc.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/foc_pkg.sv
// -----------------------------------------------------------------------------
// foc_pkg
// Shared definitions for the FOC current-loop blocks.
//   state_t     : PI controller sequencer states (IDLE plus six per-channel steps)
//   DEF_*       : default fixed-point widths and fraction counts
//   sat_signed  : clamps a wide signed value to the range of a narrower
//                 signed width; the caller truncates the result to that width
// -----------------------------------------------------------------------------
package foc_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERR,
      S_MP,
      S_MI,
      S_SUM,
      S_MAW,
      S_UPD
   } state_t;

   localparam int DEF_N_CH      = 2;
   localparam int DEF_I_WIDTH   = 16;
   localparam int DEF_I_FRAC    = 12;
   localparam int DEF_K_WIDTH   = 16;
   localparam int DEF_K_FRAC    = 12;
   localparam int DEF_ACC_WIDTH = 40;

   // Working width of sat_signed; every value handed to it must fit here.
   localparam int SAT_W = 64;

   function automatic logic signed [SAT_W-1:0] sat_signed(
      input logic signed [SAT_W-1:0] value,
      input int                      width
   );
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (value > max_v) return max_v;
      if (value < min_v) return min_v;
      return value;
   endfunction

endpackage

// File: rtl/pi_controller_mc_if.sv
// -----------------------------------------------------------------------------
// pi_controller_mc_if
// Request/response bundle of the multi-channel PI controller.
//   start, clear      : run request / integrator clear (master -> slave)
//   r, y              : per-channel reference and feedback (signed, I_WIDTH)
//   kp, ki, kaw       : per-channel gains (signed, K_WIDTH)
//   u_min, u_max      : shared output clamp limits
//   busy, done        : run in progress / one-cycle completion pulse
//   u, sat            : clamped outputs and per-channel clamp flags
// Modport master drives requests, modport slave is the controller side.
// -----------------------------------------------------------------------------
interface pi_controller_mc_if
   import foc_pkg::*;
#(
   parameter int N_CH    = DEF_N_CH,
   parameter int I_WIDTH = DEF_I_WIDTH,
   parameter int K_WIDTH = DEF_K_WIDTH
);

   logic                      start;
   logic                      clear;
   logic signed [I_WIDTH-1:0] r     [N_CH];
   logic signed [I_WIDTH-1:0] y     [N_CH];
   logic signed [K_WIDTH-1:0] kp    [N_CH];
   logic signed [K_WIDTH-1:0] ki    [N_CH];
   logic signed [K_WIDTH-1:0] kaw   [N_CH];
   logic signed [I_WIDTH-1:0] u_min;
   logic signed [I_WIDTH-1:0] u_max;
   logic                      busy;
   logic                      done;
   logic signed [I_WIDTH-1:0] u     [N_CH];
   logic        [N_CH-1:0]    sat;

   modport master (
      output start, clear, r, y, kp, ki, kaw, u_min, u_max,
      input  busy, done, u, sat
   );

   modport slave (
      input  start, clear, r, y, kp, ki, kaw, u_min, u_max,
      output busy, done, u, sat
   );

endinterface

// File: rtl/pi_clamp.sv
// -----------------------------------------------------------------------------
// pi_clamp
// Combinational limiter: clamps a wide signed value into [lo, hi].
//   v   : value to limit (V_WIDTH, signed, V_WIDTH >= L_WIDTH)
//   lo  : lower limit (L_WIDTH, signed)
//   hi  : upper limit (L_WIDTH, signed)
//   c   : clamped value (L_WIDTH)
//   sat : 1 when either limit was applied
// The upper check runs first and the lower check sees its result, so an
// inverted window (lo > hi) always resolves to lo.
// -----------------------------------------------------------------------------
module pi_clamp #(
   parameter int V_WIDTH = 29,
   parameter int L_WIDTH = 16
) (
   input  logic signed [V_WIDTH-1:0] v,
   input  logic signed [L_WIDTH-1:0] lo,
   input  logic signed [L_WIDTH-1:0] hi,
   output logic signed [L_WIDTH-1:0] c,
   output logic                      sat
);

   logic signed [V_WIDTH-1:0] lo_x;
   logic signed [V_WIDTH-1:0] hi_x;
   logic signed [V_WIDTH-1:0] t;

   assign lo_x = V_WIDTH'(lo);
   assign hi_x = V_WIDTH'(hi);

   // NOTE: every variable written here gets a value before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      t   = v;
      sat = 1'b0;
      if (t > hi_x) begin
         t   = hi_x;
         sat = 1'b1;
      end
      if (t < lo_x) begin
         t   = lo_x;
         sat = 1'b1;
      end
      c = t[L_WIDTH-1:0];
   end

endmodule

// File: rtl/pi_controller_mc.sv
// -----------------------------------------------------------------------------
// pi_controller_mc
// Time-multiplexed PI controller for the FOC current loops. One shared
// multiplier serves all channels; each channel takes six cycles
// (ERR, MP, MI, SUM, MAW, UPD), channels run in order 0..N_CH-1.
//   clk  : clock
//   rst  : synchronous reset, active high
//   bus  : pi_controller_mc_if.slave (start/clear, r/y, gains, limits,
//          busy/done, u/sat)
// Inputs are snapshotted when start is accepted in IDLE. Outputs u/sat are
// double-buffered and all change in the cycle done is high.
// Integrators hold I_FRAC+K_FRAC fractional bits and saturate, never wrap.
// -----------------------------------------------------------------------------
module pi_controller_mc
   import foc_pkg::*;
#(
   parameter int N_CH        = DEF_N_CH,
   parameter int I_WIDTH     = DEF_I_WIDTH,
   parameter int I_FRAC      = DEF_I_FRAC,
   parameter int K_WIDTH     = DEF_K_WIDTH,
   parameter int K_FRAC      = DEF_K_FRAC,
   parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
   parameter int ANTI_WINDUP = 1
) (
   input  logic               clk,
   input  logic               rst,
   pi_controller_mc_if.slave  bus
);

   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int E_W      = I_WIDTH + 1;            // r - y never overflows
   localparam int M_W      = K_WIDTH + ACC_WIDTH;    // full shared product
   localparam int S_W      = ACC_WIDTH + 1;          // p + integ
   localparam int ACC_FRAC = I_FRAC + K_FRAC;
   localparam int SHIFT    = ACC_FRAC - I_FRAC;      // back to output scaling
   localparam int V_W      = S_W - SHIFT;
   localparam int U_W      = ACC_WIDTH + 2;          // integ + pi + aw

   // ---------------- state and registers ----------------
   state_t                      state_q, state_d;
   logic [CH_W-1:0]             ch_q;
   logic                        busy_q, done_q;
   logic signed [I_WIDTH-1:0]   u_q     [N_CH];
   logic        [N_CH-1:0]      sat_q;

   logic signed [I_WIDTH-1:0]   r_s     [N_CH];
   logic signed [I_WIDTH-1:0]   y_s     [N_CH];
   logic signed [K_WIDTH-1:0]   kp_s    [N_CH];
   logic signed [K_WIDTH-1:0]   ki_s    [N_CH];
   logic signed [K_WIDTH-1:0]   kaw_s   [N_CH];
   logic signed [I_WIDTH-1:0]   umin_s, umax_s;

   logic signed [E_W-1:0]       e_q;
   logic signed [ACC_WIDTH-1:0] p_q, pi_q, aw_q;
   logic signed [V_W-1:0]       v_q;
   logic signed [I_WIDTH-1:0]   uc_q;
   logic signed [I_WIDTH-1:0]   u_buf   [N_CH];
   logic        [N_CH-1:0]      sat_buf;
   logic signed [ACC_WIDTH-1:0] integ_q [N_CH];

   // ---------------- control ----------------
   logic last_ch, accept, do_clear, load_out;

   assign last_ch = (ch_q == CH_W'(N_CH - 1));

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      do_clear = 1'b0;
      load_out = 1'b0;
      case (state_q)
         S_IDLE: begin
            do_clear = bus.clear;
            if (bus.start) begin
               accept  = 1'b1;
               state_d = S_ERR;
            end
         end
         S_ERR: state_d = S_MP;
         S_MP:  state_d = S_MI;
         S_MI:  state_d = S_SUM;
         S_SUM: state_d = S_MAW;
         S_MAW: begin
            state_d  = S_UPD;
            // Publishing here makes done coincide with the last UPD cycle,
            // i.e. 6*N_CH cycles after the start cycle.
            load_out = last_ch;
         end
         S_UPD: state_d = last_ch ? S_IDLE : S_ERR;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- datapath (combinational) ----------------
   logic signed [K_WIDTH-1:0]   mul_k;
   logic signed [ACC_WIDTH-1:0] mul_x;
   logic signed [M_W-1:0]       prod;
   logic signed [ACC_WIDTH-1:0] mul_sat;
   logic signed [E_W-1:0]       e_c;
   logic signed [S_W-1:0]       sum_c;
   logic signed [V_W-1:0]       v_c;
   logic signed [I_WIDTH-1:0]   uc_c;
   logic                        sat_c;
   logic signed [ACC_WIDTH-1:0] upd_c;

   // One multiplier: kp*e in MP, ki*e in MI, kaw*(u_c - v) in MAW.
   always_comb begin
      mul_k = kp_s[ch_q];
      mul_x = ACC_WIDTH'(e_q);
      case (state_q)
         S_MI:  mul_k = ki_s[ch_q];
         S_MAW: begin
            mul_k = kaw_s[ch_q];
            mul_x = ACC_WIDTH'(uc_q) - ACC_WIDTH'(v_q);
         end
         default: ;
      endcase
   end

   assign prod    = M_W'(mul_k) * M_W'(mul_x);
   assign mul_sat = ACC_WIDTH'(sat_signed(SAT_W'(prod), ACC_WIDTH));

   assign e_c   = E_W'(r_s[ch_q]) - E_W'(y_s[ch_q]);
   assign sum_c = S_W'(p_q) + S_W'(integ_q[ch_q]);
   assign v_c   = V_W'(sum_c >>> SHIFT);
   assign upd_c = ACC_WIDTH'(sat_signed(
                     SAT_W'(U_W'(integ_q[ch_q]) + U_W'(pi_q) + U_W'(aw_q)),
                     ACC_WIDTH));

   pi_clamp #(
      .V_WIDTH (V_W),
      .L_WIDTH (I_WIDTH)
   ) u_clamp (
      .v   (v_c),
      .lo  (umin_s),
      .hi  (umax_s),
      .c   (uc_c),
      .sat (sat_c)
   );

   // ---------------- sequential ----------------
   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values, regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sat_q   <= '0;
         for (int i = 0; i < N_CH; i++) u_q[i] <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= load_out;
         if (accept) begin
            busy_q <= 1'b1;
            ch_q   <= '0;
         end else if (load_out) begin
            busy_q <= 1'b0;
         end
         if (state_q == S_UPD) ch_q <= last_ch ? '0 : ch_q + 1'b1;
         if (load_out) begin
            u_q   <= u_buf;
            sat_q <= sat_buf;
         end
      end
   end

   // Integrators: clear only acts in IDLE; with start in the same cycle it
   // still lands before the first SUM reads the integrator.
   always_ff @(posedge clk) begin
      if (rst || do_clear) begin
         for (int i = 0; i < N_CH; i++) integ_q[i] <= '0;
      end else if (state_q == S_UPD) begin
         integ_q[ch_q] <= upd_c;
      end
   end

   // NOTE: snapshot and pipeline registers carry no reset; each run writes
   // every one of them before it is read, so reset would only add fan-out.
   always_ff @(posedge clk) begin
      if (accept) begin
         r_s    <= bus.r;
         y_s    <= bus.y;
         kp_s   <= bus.kp;
         ki_s   <= bus.ki;
         kaw_s  <= bus.kaw;
         umin_s <= bus.u_min;
         umax_s <= bus.u_max;
      end
      case (state_q)
         S_ERR: e_q  <= e_c;
         S_MP:  p_q  <= mul_sat;
         S_MI:  pi_q <= mul_sat;
         S_SUM: begin
            v_q            <= v_c;
            uc_q           <= uc_c;
            u_buf[ch_q]    <= uc_c;
            sat_buf[ch_q]  <= sat_c;
         end
         // The multiply still happens with anti-windup off so run length
         // does not depend on the mode.
         S_MAW: aw_q <= (ANTI_WINDUP != 0) ? mul_sat : '0;
         default: ;
      endcase
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.u    = u_q;
   assign bus.sat  = sat_q;

endmodule

// File: tb/tb_pi_controller_mc.sv
// -----------------------------------------------------------------------------
// tb_pi_controller_mc
// Directed bench for pi_controller_mc. Two instances see identical inputs:
// dut_aw with back-calculation anti-windup, dut_naw without it.
// -----------------------------------------------------------------------------
module tb_pi_controller_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               start;
   logic               clear;
   logic signed [15:0] r     [2];
   logic signed [15:0] y     [2];
   logic signed [15:0] kp    [2];
   logic signed [15:0] ki    [2];
   logic signed [15:0] kaw   [2];
   logic signed [15:0] u_min;
   logic signed [15:0] u_max;

   int checks = 0;
   int errors = 0;

   pi_controller_mc_if #(.N_CH(2), .I_WIDTH(16), .K_WIDTH(16)) bus_aw ();
   pi_controller_mc_if #(.N_CH(2), .I_WIDTH(16), .K_WIDTH(16)) bus_naw ();

   assign bus_aw.start  = start;   assign bus_naw.start  = start;
   assign bus_aw.clear  = clear;   assign bus_naw.clear  = clear;
   assign bus_aw.r      = r;       assign bus_naw.r      = r;
   assign bus_aw.y      = y;       assign bus_naw.y      = y;
   assign bus_aw.kp     = kp;      assign bus_naw.kp     = kp;
   assign bus_aw.ki     = ki;      assign bus_naw.ki     = ki;
   assign bus_aw.kaw    = kaw;     assign bus_naw.kaw    = kaw;
   assign bus_aw.u_min  = u_min;   assign bus_naw.u_min  = u_min;
   assign bus_aw.u_max  = u_max;   assign bus_naw.u_max  = u_max;

   pi_controller_mc #(.ANTI_WINDUP(1)) dut_aw (
      .clk (clk),
      .rst (rst),
      .bus (bus_aw)
   );

   pi_controller_mc #(.ANTI_WINDUP(0)) dut_naw (
      .clk (clk),
      .rst (rst),
      .bus (bus_naw)
   );

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One run: start is raised in cycle t; n counts edges after that. A
   // restart pulse or clear pulse can be placed at cycle n (clear_at 0 means
   // clear together with start). Every run lasts a fixed 20 cycles.
   task automatic run_once(input int restart_at, input int clear_at,
                           output int done_cycle, output int done_count,
                           output logic busy_first, output logic busy_at_done);
      done_cycle   = -1;
      done_count   = 0;
      busy_first   = 1'bx;
      busy_at_done = 1'bx;
      @(posedge clk); #1;
      start = 1'b1;
      clear = (clear_at == 0);
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         start = (n == restart_at);
         clear = (n == clear_at);
         if (n == 1) busy_first = bus_aw.busy;
         if (bus_aw.done === 1'b1) begin
            done_count++;
            if (done_cycle < 0) begin
               done_cycle   = n;
               busy_at_done = bus_aw.busy;
            end
         end
      end
      start = 1'b0;
      clear = 1'b0;
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
   endtask

   task automatic set_gains(input logic signed [15:0] p, input logic signed [15:0] i,
                            input logic signed [15:0] a);
      for (int c = 0; c < 2; c++) begin
         kp[c]  = p;
         ki[c]  = i;
         kaw[c] = a;
      end
   endtask

   initial begin
      int   dc, dn, bad, rst_dones;
      logic b1, bd;
      int   exp_u0 [5];

      rst   = 1'b1;
      start = 1'b0;
      clear = 1'b0;
      r[0] = '0; r[1] = '0; y[0] = '0; y[1] = '0;
      set_gains(16'sd0, 16'sd0, 16'sd0);
      u_min = -16'sd4000;
      u_max = 16'sd4000;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", bus_aw.busy, 0);
      check("reset_done", bus_aw.done, 0);
      check("reset_u0",   bus_aw.u[0], 0);
      check("reset_u1",   bus_aw.u[1], 0);
      check("reset_sat",  bus_aw.sat,  0);
      rst = 1'b0;

      // Proportional only
      set_gains(16'sd4096, 16'sd0, 16'sd0);
      r[0] = 16'sd2048; r[1] = -16'sd1024;
      run_once(-1, -1, dc, dn, b1, bd);
      check("p_done_cycle", dc, 12);
      check("p_done_count", dn, 1);
      check("p_busy_first", b1, 1);
      check("p_busy_at_done", bd, 0);
      check("p_u0", bus_aw.u[0], 2048);
      check("p_u1", bus_aw.u[1], -1024);
      check("p_sat", bus_aw.sat, 0);

      // Integral only: outputs lag the integrator by one run
      pulse_clear();
      set_gains(16'sd0, 16'sd4096, 16'sd0);
      r[0] = 16'sd256; y[0] = 16'sd0;
      r[1] = 16'sd100; y[1] = 16'sd356;
      u_min = -16'sd30000; u_max = 16'sd30000;
      for (int k = 0; k < 3; k++) begin
         run_once(-1, -1, dc, dn, b1, bd);
         check($sformatf("i_u0_run%0d", k), bus_aw.u[0], 256 * k);
         check($sformatf("i_u1_run%0d", k), bus_aw.u[1], -256 * k);
      end
      // clear while busy has no effect
      run_once(-1, 4, dc, dn, b1, bd);
      check("i_u0_run3", bus_aw.u[0], 768);
      run_once(-1, -1, dc, dn, b1, bd);
      check("busyclear_u0", bus_aw.u[0], 1024);
      check("busyclear_u1", bus_aw.u[1], -1024);
      // clear in IDLE
      pulse_clear();
      set_gains(16'sd0, 16'sd0, 16'sd0);
      run_once(-1, -1, dc, dn, b1, bd);
      check("idleclear_u0", bus_aw.u[0], 0);
      check("idleclear_u1", bus_aw.u[1], 0);
      // clear together with start
      set_gains(16'sd0, 16'sd4096, 16'sd0);
      run_once(-1, -1, dc, dn, b1, bd);
      run_once(-1, 0, dc, dn, b1, bd);
      check("startclear_u0", bus_aw.u[0], 0);
      run_once(-1, -1, dc, dn, b1, bd);
      check("after_startclear_u0", bus_aw.u[0], 256);

      // Clamp
      pulse_clear();
      set_gains(16'sd4096, 16'sd0, 16'sd0);
      r[0] = 16'sd2000;  y[0] = 16'sd0;
      r[1] = -16'sd1000; y[1] = 16'sd0;
      u_min = -16'sd1000; u_max = 16'sd1000;
      run_once(-1, -1, dc, dn, b1, bd);
      check("clamp_u0", bus_aw.u[0], 1000);
      check("clamp_u1_at_limit", bus_aw.u[1], -1000);
      check("clamp_sat", bus_aw.sat, 1);
      u_min = 16'sd1200;
      run_once(-1, -1, dc, dn, b1, bd);
      check("inverted_u0", bus_aw.u[0], 1200);
      check("inverted_u1", bus_aw.u[1], 1200);
      check("inverted_sat", bus_aw.sat, 3);

      // Anti-windup
      pulse_clear();
      set_gains(16'sd0, 16'sd4096, 16'sd4096);
      r[0] = 16'sd256; y[0] = 16'sd0;
      r[1] = 16'sd256; y[1] = 16'sd0;
      u_min = -16'sd30000; u_max = 16'sd300;
      exp_u0 = '{0, 256, 300, 300, 300};
      for (int k = 0; k < 5; k++) begin
         run_once(-1, -1, dc, dn, b1, bd);
         check($sformatf("aw_u0_run%0d", k), bus_aw.u[0], exp_u0[k]);
         check($sformatf("naw_u0_run%0d", k), bus_naw.u[0], exp_u0[k]);
      end
      check("aw_integ0", dut_aw.integ_q[0], 556 * 4096);
      check("naw_integ0", dut_naw.integ_q[0], 1280 * 4096);
      set_gains(16'sd0, 16'sd0, 16'sd0);
      u_max = 16'sd30000;
      run_once(-1, -1, dc, dn, b1, bd);
      check("aw_v_unclamped", bus_aw.u[0], 556);
      check("aw_v_unclamped_ch1", bus_aw.u[1], 556);
      check("naw_v_unclamped", bus_naw.u[0], 1280);

      // Start while busy is ignored
      pulse_clear();
      set_gains(16'sd4096, 16'sd0, 16'sd0);
      r[0] = 16'sd2048; r[1] = -16'sd1024; y[0] = '0; y[1] = '0;
      run_once(3, -1, dc, dn, b1, bd);
      check("restart_done_cycle", dc, 12);
      check("restart_done_count", dn, 1);

      // Integrator saturation at both signed limits
      pulse_clear();
      set_gains(16'sd0, 16'sd32767, 16'sd0);
      r[0] = 16'sd32767;  y[0] = -16'sd32768;
      r[1] = -16'sd32768; y[1] = 16'sd32767;
      u_min = -16'sd32768; u_max = 16'sd32767;
      bad = 0;
      for (int k = 1; k <= 260; k++) begin
         run_once(-1, -1, dc, dn, b1, bd);
         if (k >= 2 && (bus_aw.u[0] !== 16'sd32767 || bus_aw.u[1] !== -16'sd32768))
            bad++;
      end
      check("sat_runs_off_limit", bad, 0);
      check("sat_integ0_max", dut_aw.integ_q[0], 64'sd549755813887);
      check("sat_integ1_min", dut_aw.integ_q[1], -64'sd549755813888);
      check("sat_flags", bus_aw.sat, 3);

      // Reset in the middle of a run
      pulse_clear();
      set_gains(16'sd4096, 16'sd4096, 16'sd0);
      r[0] = 16'sd2048; r[1] = -16'sd1024; y[0] = '0; y[1] = '0;
      u_min = -16'sd4000; u_max = 16'sd4000;
      run_once(-1, -1, dc, dn, b1, bd);
      check("prerst_u0", bus_aw.u[0], 2048);
      rst_dones = 0;
      @(posedge clk); #1 start = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (n == 1) start = 1'b0;
         if (bus_aw.done === 1'b1) rst_dones++;
         if (n == 5) begin
            check("midrun_busy", bus_aw.busy, 1);
            rst = 1'b1;
         end
         if (n == 6) begin
            check("rst_busy", bus_aw.busy, 0);
            check("rst_u0", bus_aw.u[0], 0);
            check("rst_u1", bus_aw.u[1], 0);
            check("rst_sat", bus_aw.sat, 0);
            rst = 1'b0;
         end
      end
      check("rst_no_done", rst_dones, 0);
      set_gains(16'sd0, 16'sd4096, 16'sd0);
      r[0] = 16'sd256; y[0] = 16'sd0;
      r[1] = 16'sd100; y[1] = 16'sd356;
      run_once(-1, -1, dc, dn, b1, bd);
      check("postrst_done_cycle", dc, 12);
      check("postrst_u0", bus_aw.u[0], 0);
      check("postrst_u1", bus_aw.u[1], 0);
      run_once(-1, -1, dc, dn, b1, bd);
      check("postrst_run2_u0", bus_aw.u[0], 256);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
